// File: rtl/pol_core.sv
`default_nettype none
// ============================================================================
//  Module      : pol_core
//  Description : Single pooling core of the POL stage. Streams neighbour
//                indices from the map buffer straight through as feature-row
//                read addresses, reduces each group of K+1 returned rows with
//                a lane-wise unsigned max and emits one pooled row per output
//                point toward the global buffer.
//
//  Ports
//    clk, rst                 clock, synchronous active-high reset
//    CCUPOL_CfgVld/Rdy        job command handshake
//    CCUPOL_NumPnt            output points in job, minus 1
//    CCUPOL_K                 neighbours per point, minus 1
//    POLCCU_Done              one-cycle pulse after the job's last row
//    MAPPOL_IdxVld/Idx        neighbour index stream in
//    POLMAP_IdxRdy            neighbour index ready
//    POLMIF_AddrVld/Addr      read address toward the crossbar
//    MIFPOL_Rdy               crossbar accepts address
//    MIFPOL_OfmVld/Ofm        returned feature row
//    POLMIF_OfmRdy            returned row ready
//    POLGLB_FmVld/Fm          pooled row out
//    GLBPOL_FmRdy             global buffer accepts pooled row
//
//  Revision    : 1.0  initial release
// ============================================================================
module pol_core #(
    parameter int IDX_WIDTH      = 10,
    parameter int ACT_WIDTH      = 8,
    parameter int POOL_COMP_CORE = 64,
    parameter int MAP_WIDTH      = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    // job command
    input  logic                                CCUPOL_CfgVld,
    output logic                                CCUPOL_CfgRdy,
    input  logic [IDX_WIDTH-1:0]                CCUPOL_NumPnt,
    input  logic [MAP_WIDTH-1:0]                CCUPOL_K,
    output logic                                POLCCU_Done,
    // neighbour index stream
    input  logic                                MAPPOL_IdxVld,
    input  logic [IDX_WIDTH-1:0]                MAPPOL_Idx,
    output logic                                POLMAP_IdxRdy,
    // read address toward crossbar
    output logic                                POLMIF_AddrVld,
    output logic [IDX_WIDTH-1:0]                POLMIF_Addr,
    input  logic                                MIFPOL_Rdy,
    // returned rows from crossbar
    input  logic                                MIFPOL_OfmVld,
    input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] MIFPOL_Ofm,
    output logic                                POLMIF_OfmRdy,
    // pooled rows toward global buffer
    output logic                                POLGLB_FmVld,
    output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLGLB_Fm,
    input  logic                                GLBPOL_FmRdy
);

    localparam int c_ROW_W = ACT_WIDTH * POOL_COMP_CORE;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_OUT  = 2'd2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;

    logic [IDX_WIDTH-1:0]   r_num_pnt;
    logic [MAP_WIDTH-1:0]   r_k;
    logic [IDX_WIDTH-1:0]   r_pnt_cnt;
    // One bit wider than K so that K all-ones (2^MAP_WIDTH neighbours)
    // can be counted past without wrapping back into the open window.
    logic [MAP_WIDTH:0]     r_req_cnt;
    logic [MAP_WIDTH:0]     r_rsp_cnt;
    logic [c_ROW_W-1:0]     r_acc;
    logic [c_ROW_W-1:0]     w_acc_nxt;
    logic                   r_done;

    // ------------------------------------------------------------------
    // Qualifiers and handshakes
    // ------------------------------------------------------------------
    logic [MAP_WIDTH:0]     w_k_ext;
    logic                   w_req_open;
    logic                   w_rsp_open;
    logic                   w_cfg_hs;
    logic                   w_addr_hs;
    logic                   w_ret_hs;
    logic                   w_out_hs;
    logic                   w_last_ret;
    logic                   w_last_pnt;
    logic                   w_first_ret;

    assign w_k_ext     = {1'b0, r_k};
    assign w_req_open  = (r_req_cnt <= w_k_ext);
    assign w_rsp_open  = (r_rsp_cnt <= w_k_ext);

    assign w_cfg_hs    = CCUPOL_CfgVld  & CCUPOL_CfgRdy;
    assign w_addr_hs   = POLMIF_AddrVld & MIFPOL_Rdy;
    assign w_ret_hs    = MIFPOL_OfmVld  & POLMIF_OfmRdy;
    assign w_out_hs    = POLGLB_FmVld   & GLBPOL_FmRdy;

    assign w_first_ret = (r_rsp_cnt == '0);
    assign w_last_ret  = w_ret_hs & (r_rsp_cnt == w_k_ext);
    assign w_last_pnt  = (r_pnt_cnt == r_num_pnt);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_cfg_hs) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (w_last_ret) begin
                    w_state_nxt = c_OUT;
                end
            end
            c_OUT: begin
                if (w_out_hs) begin
                    w_state_nxt = w_last_pnt ? c_IDLE : c_RUN;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // The address path is a pure pass-through: valid follows the map
    // buffer's valid and ready follows the crossbar's ready, both gated by
    // the request window, so no valid here ever looks at its own ready.
    // ------------------------------------------------------------------
    always_comb begin
        CCUPOL_CfgRdy  = 1'b0;
        POLMAP_IdxRdy  = 1'b0;
        POLMIF_AddrVld = 1'b0;
        POLMIF_OfmRdy  = 1'b0;
        POLGLB_FmVld   = 1'b0;
        case (r_state)
            c_IDLE: begin
                CCUPOL_CfgRdy = 1'b1;
            end
            c_RUN: begin
                POLMIF_AddrVld = MAPPOL_IdxVld & w_req_open;
                POLMAP_IdxRdy  = MIFPOL_Rdy    & w_req_open;
                POLMIF_OfmRdy  = w_rsp_open;
            end
            c_OUT: begin
                POLGLB_FmVld = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign POLMIF_Addr = MAPPOL_Idx;
    assign POLGLB_Fm   = r_acc;
    assign POLCCU_Done = r_done;

    // ------------------------------------------------------------------
    // Job / point counters and done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_pnt <= '0;
            r_k       <= '0;
            r_pnt_cnt <= '0;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_cfg_hs) begin
                        r_num_pnt <= CCUPOL_NumPnt;
                        r_k       <= CCUPOL_K;
                        r_pnt_cnt <= '0;
                        r_req_cnt <= '0;
                        r_rsp_cnt <= '0;
                    end
                end
                c_RUN: begin
                    // Address and return handshakes are independent and may
                    // both fire in the same cycle.
                    if (w_addr_hs) begin
                        r_req_cnt <= r_req_cnt + 1'b1;
                    end
                    if (w_ret_hs) begin
                        r_rsp_cnt <= r_rsp_cnt + 1'b1;
                    end
                end
                c_OUT: begin
                    if (w_out_hs) begin
                        r_req_cnt <= '0;
                        r_rsp_cnt <= '0;
                        if (w_last_pnt) begin
                            r_done <= 1'b1;
                        end else begin
                            r_pnt_cnt <= r_pnt_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Lane-wise unsigned max reduction. The first return of a point loads
    // the accumulator outright so no clear cycle is needed between points.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < POOL_COMP_CORE; g++) begin : g_lane
        logic [ACT_WIDTH-1:0] w_in;
        logic [ACT_WIDTH-1:0] w_cur;

        assign w_in  = MIFPOL_Ofm[g*ACT_WIDTH +: ACT_WIDTH];
        assign w_cur = r_acc[g*ACT_WIDTH +: ACT_WIDTH];
        assign w_acc_nxt[g*ACT_WIDTH +: ACT_WIDTH] =
            (w_first_ret || (w_in > w_cur)) ? w_in : w_cur;
    end

    // Only loads on a return handshake, which cannot occur in OUT, so the
    // pooled row is held steady while the global buffer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_ret_hs) begin
            r_acc <= w_acc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pol_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pol_core
//  Description : Self-checking bench for pol_core. Expected addresses and
//                pooled rows are queued as stimulus is driven and compared
//                when the DUT hands them off.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pol_core;

    localparam int IW = 10;
    localparam int AW = 8;
    localparam int NL = 64;
    localparam int MW = 5;
    localparam int W  = AW * NL;
    localparam int c_BUDGET = 20000;

    logic          clk = 1'b0;
    logic          rst;
    logic          CCUPOL_CfgVld;
    logic          CCUPOL_CfgRdy;
    logic [IW-1:0] CCUPOL_NumPnt;
    logic [MW-1:0] CCUPOL_K;
    logic          POLCCU_Done;
    logic          MAPPOL_IdxVld;
    logic [IW-1:0] MAPPOL_Idx;
    logic          POLMAP_IdxRdy;
    logic          POLMIF_AddrVld;
    logic [IW-1:0] POLMIF_Addr;
    logic          MIFPOL_Rdy;
    logic          MIFPOL_OfmVld;
    logic [W-1:0]  MIFPOL_Ofm;
    logic          POLMIF_OfmRdy;
    logic          POLGLB_FmVld;
    logic [W-1:0]  POLGLB_Fm;
    logic          GLBPOL_FmRdy;

    pol_core #(
        .IDX_WIDTH      (IW),
        .ACT_WIDTH      (AW),
        .POOL_COMP_CORE (NL),
        .MAP_WIDTH      (MW)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .CCUPOL_CfgVld  (CCUPOL_CfgVld),
        .CCUPOL_CfgRdy  (CCUPOL_CfgRdy),
        .CCUPOL_NumPnt  (CCUPOL_NumPnt),
        .CCUPOL_K       (CCUPOL_K),
        .POLCCU_Done    (POLCCU_Done),
        .MAPPOL_IdxVld  (MAPPOL_IdxVld),
        .MAPPOL_Idx     (MAPPOL_Idx),
        .POLMAP_IdxRdy  (POLMAP_IdxRdy),
        .POLMIF_AddrVld (POLMIF_AddrVld),
        .POLMIF_Addr    (POLMIF_Addr),
        .MIFPOL_Rdy     (MIFPOL_Rdy),
        .MIFPOL_OfmVld  (MIFPOL_OfmVld),
        .MIFPOL_Ofm     (MIFPOL_Ofm),
        .POLMIF_OfmRdy  (POLMIF_OfmRdy),
        .POLGLB_FmVld   (POLGLB_FmVld),
        .POLGLB_Fm      (POLGLB_Fm),
        .GLBPOL_FmRdy   (GLBPOL_FmRdy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [IW-1:0] idx_arr[$];
    logic [W-1:0]  ret_arr[$];
    logic [IW-1:0] exp_addr[$];
    logic [W-1:0]  exp_row[$];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] lane_max(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int l = 0; l < NL; l++) begin
            r[l*AW +: AW] = (a[l*AW +: AW] > b[l*AW +: AW]) ? a[l*AW +: AW] : b[l*AW +: AW];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    task automatic idle_inputs();
        CCUPOL_CfgVld = 1'b0;
        CCUPOL_NumPnt = '0;
        CCUPOL_K      = '0;
        MAPPOL_IdxVld = 1'b0;
        MAPPOL_Idx    = '0;
        MIFPOL_Rdy    = 1'b0;
        MIFPOL_OfmVld = 1'b0;
        MIFPOL_Ofm    = '0;
        GLBPOL_FmRdy  = 1'b0;
    endtask

    // Run one job using idx_arr / ret_arr. pct = stall percentage on every
    // partner, hold = cycles GLBPOL_FmRdy is forced low on the first OUT,
    // rst_mid = pulse reset two returns into the second point.
    task automatic run_job(input int np, input int k, input int pct, input int hold, input bit rst_mid);
        int total, ii, ia, ir, io, cyc, hold_left;
        bit hs_idx, hs_addr, hs_ret, hs_out;
        bit prev_stall, exp_fmvld, exp_done, finished, do_rst;
        logic [W-1:0]  prev_fm, run_max;
        logic [IW-1:0] ea;

        total = (np + 1) * (k + 1);
        ii = 0; ia = 0; ir = 0; io = 0; cyc = 0; hold_left = hold;
        prev_stall = 0; exp_fmvld = 0; exp_done = 0; finished = 0; do_rst = 0;
        prev_fm = '0; run_max = '0;
        exp_addr.delete();
        exp_row.delete();

        @(posedge clk); #1;
        CCUPOL_CfgVld = 1'b1;
        CCUPOL_NumPnt = np[IW-1:0];
        CCUPOL_K      = k[MW-1:0];
        @(negedge clk);
        check("cfg_rdy", CCUPOL_CfgRdy, 1);
        @(posedge clk); #1;
        CCUPOL_CfgVld = 1'b0;

        while (!finished && cyc < c_BUDGET) begin
            // ---- drive this cycle's inputs ----
            if (!MAPPOL_IdxVld && ii < total && $urandom_range(99) >= pct) begin
                MAPPOL_IdxVld = 1'b1;
                MAPPOL_Idx    = idx_arr[ii];
                exp_addr.push_back(idx_arr[ii]);
            end
            MIFPOL_Rdy = ($urandom_range(99) >= pct);
            if (!MIFPOL_OfmVld && ir < ia && $urandom_range(99) >= pct) begin
                MIFPOL_OfmVld = 1'b1;
                MIFPOL_Ofm    = ret_arr[ir];
                run_max = (ir % (k + 1) == 0) ? ret_arr[ir] : lane_max(run_max, ret_arr[ir]);
                if (ir % (k + 1) == k) begin
                    exp_row.push_back(run_max);
                end
            end
            if (hold_left > 0 && POLGLB_FmVld) begin
                GLBPOL_FmRdy = 1'b0;
                hold_left--;
            end else begin
                GLBPOL_FmRdy = ($urandom_range(99) >= pct);
            end

            // ---- sample and compare mid-cycle ----
            @(negedge clk);
            hs_idx  = MAPPOL_IdxVld  && POLMAP_IdxRdy;
            hs_addr = POLMIF_AddrVld && MIFPOL_Rdy;
            hs_ret  = MIFPOL_OfmVld  && POLMIF_OfmRdy;
            hs_out  = POLGLB_FmVld   && GLBPOL_FmRdy;

            if (hs_addr) begin
                if (exp_addr.size() == 0) begin
                    check("addr_extra", exp_addr.size(), 1);
                end else begin
                    ea = exp_addr.pop_front();
                    check("addr", POLMIF_Addr, ea);
                end
            end
            if (POLGLB_FmVld) begin
                check("out_quiet", {POLMAP_IdxRdy, POLMIF_OfmRdy, POLMIF_AddrVld}, 0);
            end
            if (prev_stall) begin
                check("fm_hold", {POLGLB_FmVld, POLGLB_Fm}, {1'b1, prev_fm});
            end
            if (exp_fmvld) begin
                check("fm_latency", POLGLB_FmVld, 1);
            end
            if (hs_out) begin
                if (exp_row.size() == 0) begin
                    check("row_extra", exp_row.size(), 1);
                end else begin
                    check("row", POLGLB_Fm, exp_row.pop_front());
                end
            end
            if (POLCCU_Done || exp_done) begin
                check("done", POLCCU_Done, exp_done);
            end
            if (exp_done) begin
                check("cfg_rdy_after", CCUPOL_CfgRdy, 1);
                finished = 1;
            end
            prev_stall = POLGLB_FmVld && !GLBPOL_FmRdy;
            prev_fm    = POLGLB_Fm;
            exp_fmvld  = hs_ret && (ir % (k + 1) == k);
            exp_done   = hs_out && (io == np);

            // ---- advance bench state at the edge ----
            @(posedge clk); #1;
            cyc++;
            if (hs_idx) begin
                ii++;
                MAPPOL_IdxVld = 1'b0;
            end
            if (hs_addr) ia++;
            if (hs_ret) begin
                ir++;
                MIFPOL_OfmVld = 1'b0;
            end
            if (hs_out) io++;
            if (rst_mid && io == 1 && ir >= k + 3) begin
                do_rst   = 1;
                finished = 1;
            end
        end

        if (do_rst) begin
            idle_inputs();
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            // Offer an index and crossbar-ready to prove IDLE gates them off.
            MAPPOL_IdxVld = 1'b1;
            MIFPOL_Rdy    = 1'b1;
            MIFPOL_OfmVld = 1'b1;
            @(negedge clk);
            check("rst_cfg_rdy", CCUPOL_CfgRdy, 1);
            check("rst_quiet", {POLMIF_AddrVld, POLGLB_FmVld, POLMAP_IdxRdy, POLMIF_OfmRdy, POLCCU_Done}, 0);
            check("rst_fm", POLGLB_Fm, 0);
            @(negedge clk);
            check("rst_no_done", POLCCU_Done, 0);
        end else begin
            check("job_finished", finished, 1);
            check("addr_count", ia, total);
            check("row_count", io, np + 1);
            check("addr_q_empty", exp_addr.size(), 0);
            check("row_q_empty", exp_row.size(), 0);
        end
        idle_inputs();
    endtask

    task automatic load_random(input int np, input int k);
        idx_arr.delete();
        ret_arr.delete();
        for (int i = 0; i < (np + 1) * (k + 1); i++) begin
            idx_arr.push_back(IW'($urandom_range(1023)));
            ret_arr.push_back(rand_row());
        end
    endtask

    initial begin
        logic [W-1:0] r;

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_cfg_rdy", CCUPOL_CfgRdy, 1);
        check("reset_valids", {POLMIF_AddrVld, POLGLB_FmVld, POLCCU_Done}, 0);
        check("reset_fm", POLGLB_Fm, 0);

        // Job 1: 3 neighbours, directed lanes 0 and 63.
        idx_arr.delete();
        ret_arr.delete();
        idx_arr.push_back(10'd5);
        idx_arr.push_back(10'd9);
        idx_arr.push_back(10'd12);
        r = '0; r[7:0] = 8'h10; r[W-1 -: 8] = 8'h01; ret_arr.push_back(r);
        r = '0; r[7:0] = 8'hF0; r[W-1 -: 8] = 8'h00; ret_arr.push_back(r);
        r = '0; r[7:0] = 8'h80; r[W-1 -: 8] = 8'h7F; ret_arr.push_back(r);
        run_job(0, 2, 0, 0, 0);

        // Job 2: single neighbour, output equals input.
        load_random(3, 0);
        run_job(3, 0, 0, 0, 0);

        // Job 3: random stalls on every partner.
        load_random(49, 7);
        run_job(49, 7, 30, 0, 0);

        // Job 4: global buffer holds off for 20 cycles.
        load_random(1, 3);
        run_job(1, 3, 0, 20, 0);

        // Job 5: K all-ones, 0xFF only on each point's last return.
        load_random(1, 31);
        for (int i = 0; i < ret_arr.size(); i++) begin
            ret_arr[i] = ((i % 32) == 31) ? {W{1'b1}} : '0;
        end
        run_job(1, 31, 0, 0, 0);

        // Job 6: reset in the middle of point 2 of 5, then a fresh job.
        load_random(4, 3);
        run_job(4, 3, 0, 0, 1);
        load_random(2, 2);
        run_job(2, 2, 30, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
